fsm_jump_seq: RTL and testbench

- Parametrised successor to the two-output jump FSM.
- An N-state ring sequencer that advances on each rising edge of `jump`.
- Direction is selectable (up/down), with an optional inactivity timeout that returns the sequencer to state 0.
- Drives a one-cycle transition pulse (`dout_p`), a last-state level (`dout_q`) and a `timeout` pulse; sits between a control input and downstream datapath enables.

---
 rtl/fsm_jump_pkg.sv | 23 ++
 rtl/jump_edge_det.sv | 55 +++++
 rtl/fsm_jump_seq.sv | 117 +++++++++++
 tb/tb_fsm_jump_seq.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_jump_pkg.sv
// fsm_jump_pkg: shared definitions for the fsm_jump_seq ring sequencer.
//   DIR_UP / DIR_DOWN : encoding of the dir input.
//   clog2()           : constant ceil(log2) used for width defaults and
//                       elaboration-time legality checks.
package fsm_jump_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Number of bits needed to index 'value' distinct items (clog2(1) = 0).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/jump_edge_det.sv
// jump_edge_det: rising-edge detector for the jump request.
//   Build option FSM_JUMP_SYNC_EN: when defined, jump first passes through a
//   2-flop synchroniser (2 cycles of extra latency); otherwise jump is taken
//   as already synchronous to i_clk.
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_jump       raw jump request
//   o_jump_rise  one-cycle strobe on a qualifying rising edge of jump
module jump_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_jump,
  output logic o_jump_rise
);

  logic w_jump;
  logic r_jump_d;
  logic r_armed;

`ifdef FSM_JUMP_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_jump;
      r_sync2 <= r_sync1;
    end
  end

  assign w_jump = r_sync2;
`else
  assign w_jump = i_jump;
`endif

  // r_armed stays low until jump has been seen low after reset, so a request
  // that was already high when reset released never counts as an edge even
  // though r_jump_d itself clears to 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_jump_d <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_jump_d <= w_jump;
      r_armed  <= r_armed | ~i_jump;
    end
  end

  assign o_jump_rise = w_jump & ~r_jump_d & r_armed;

endmodule

// File: rtl/fsm_jump_seq.sv
// fsm_jump_seq: N-state ring sequencer advancing on each rising edge of jump,
// with selectable direction and an optional inactivity timeout back to 0.
//   Build option FSM_JUMP_SYNC_EN (see jump_edge_det): synchronise jump.
// Parameters: NUM_STATES (2..256), SW state width, HOLD_CYCLES (0 = no
//   timeout), CW timeout counter width.
// Ports:
//   clk, rst      clock / asynchronous active-high reset
//   jump          advance request (rising edges only)
//   dir           0 = step up, 1 = step down (sampled with the jump edge)
//   clr           synchronous clear to state 0 (highest priority)
//   state         current state index
//   dout_p        one-cycle pulse in the first cycle of a new state value
//   dout_q        high while state == NUM_STATES-1
//   timeout       one-cycle pulse in the first cycle after an auto-return
module fsm_jump_seq
  import fsm_jump_pkg::*;
#(
  parameter int NUM_STATES  = 4,
  parameter int SW          = clog2(NUM_STATES),
  parameter int HOLD_CYCLES = 8,
  parameter int CW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jump,
  input  logic          dir,
  input  logic          clr,
  output logic [SW-1:0] state,
  output logic          dout_p,
  output logic          dout_q,
  output logic          timeout
);

  if (NUM_STATES < 2 || NUM_STATES > 256) begin : g_chk_num_states
    $error("fsm_jump_seq: NUM_STATES must be in 2..256");
  end
  if (SW < clog2(NUM_STATES)) begin : g_chk_sw
    $error("fsm_jump_seq: SW too narrow for NUM_STATES");
  end
  if (HOLD_CYCLES < 0 || CW < clog2(HOLD_CYCLES + 1)) begin : g_chk_cw
    $error("fsm_jump_seq: CW too narrow for HOLD_CYCLES");
  end

  localparam logic [SW-1:0] LAST     = SW'(NUM_STATES - 1);
  localparam logic [CW-1:0] CNT_LAST = (HOLD_CYCLES > 0) ? CW'(HOLD_CYCLES - 1) : '0;

  logic [SW-1:0] r_state;
  logic [CW-1:0] r_cnt;
  logic          r_dout_p;
  logic          r_dout_q;
  logic          r_timeout;

  logic          w_rise;
  logic [SW-1:0] w_step;
  logic [SW-1:0] w_next;
  logic          w_expiry;

  jump_edge_det u_edge_det (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_jump      (jump),
    .o_jump_rise (w_rise)
  );

  always_comb begin
    w_step   = r_state;
    w_next   = r_state;
    w_expiry = 1'b0;

    if (dir == DIR_DOWN) begin
      w_step = (r_state == '0) ? LAST : r_state - SW'(1);
    end else begin
      w_step = (r_state == LAST) ? '0 : r_state + SW'(1);
    end

    // The state != 0 term keeps HOLD_CYCLES == 1 from firing in state 0,
    // where the counter rests at 0.
    w_expiry = (HOLD_CYCLES > 0) && (r_state != '0) && (r_cnt == CNT_LAST)
               && !w_rise && !clr;

    if (clr) begin
      w_next = '0;
    end else if (w_rise) begin
      w_next = w_step;
    end else if (w_expiry) begin
      w_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= '0;
      r_cnt     <= '0;
      r_dout_p  <= 1'b0;
      r_dout_q  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_dout_p  <= (w_next != r_state);
      r_dout_q  <= (w_next == LAST);
      r_timeout <= w_expiry;
      // Any restart of the idle interval (return to 0, new edge, clear)
      // zeroes the counter; otherwise the state is nonzero and idle.
      if (HOLD_CYCLES == 0 || w_next == '0 || w_rise || clr) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign state   = r_state;
  assign dout_p  = r_dout_p;
  assign dout_q  = r_dout_q;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_fsm_jump_seq.sv
module tb_fsm_jump_seq;

  localparam int NS   = 4;
  localparam int HOLD = 8;
`ifdef FSM_JUMP_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       jump = 1'b0;
  logic       dir  = 1'b0;
  logic       clr  = 1'b0;
  logic [1:0] state;
  logic       dout_p;
  logic       dout_q;
  logic       timeout;

  typedef struct packed {
    logic [1:0] st;
    logic       p;
    logic       q;
    logic       t;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // reference model state
  int m_state;
  int m_cnt;
  bit m_jd, m_armed, m_s1, m_s2;

  always #5 clk = ~clk;

  fsm_jump_seq #(
    .NUM_STATES (NS),
    .SW         (2),
    .HOLD_CYCLES(HOLD),
    .CW         (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .jump   (jump),
    .dir    (dir),
    .clr    (clr),
    .state  (state),
    .dout_p (dout_p),
    .dout_q (dout_q),
    .timeout(timeout)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got unfinished run, required completion");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_state = 0; m_cnt = 0;
    m_jd = 0; m_armed = 0; m_s1 = 0; m_s2 = 0;
  endtask

  // Apply the currently driven inputs for one clock: push the model's
  // expectation, let the edge happen, then record what the DUT shows.
  task automatic tick();
    bit   jin, rise, expd;
    int   nxt;
    obs_t e, o;
`ifdef FSM_JUMP_SYNC_EN
    jin = m_s2;
`else
    jin = jump;
`endif
    rise = jin && !m_jd && m_armed;
    expd = (m_state != 0) && (m_cnt == HOLD - 1) && !rise && !clr;
    if (clr) nxt = 0;
    else if (rise) begin
      if (dir) nxt = (m_state == 0) ? NS - 1 : m_state - 1;
      else     nxt = (m_state == NS - 1) ? 0 : m_state + 1;
    end
    else if (expd) nxt = 0;
    else nxt = m_state;
    e.st = 2'(nxt);
    e.p  = (nxt != m_state);
    e.q  = (nxt == NS - 1);
    e.t  = expd;
    if (nxt == 0 || rise || clr) m_cnt = 0; else m_cnt++;
    m_armed = m_armed || !jump;
    m_jd    = jin;
    m_s2    = m_s1;
    m_s1    = jump;
    m_state = nxt;
    exp_q.push_back(e);
    @(posedge clk); #1;
    o.st = state; o.p = dout_p; o.q = dout_q; o.t = timeout;
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    obs_t e, o;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({state, dout_p, dout_q, timeout} !== 5'b0) begin
        $display("FAIL reset_hold cyc%0d got st=%0d p=%b q=%b t=%b, want all 0", i, state, dout_p, dout_q, timeout);
        miscompares++;
      end
    end
    rst = 1'b0;
    model_reset();
    jump = 0;
    for (int i = 0; i < 10; i++) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        $display("FAIL reset_release got st=%0d p=%b q=%b t=%b exp st=%0d p=%b q=%b t=%b", o.st, o.p, o.q, o.t, e.st, e.p, e.q, e.t);
        miscompares++;
      end
    end
  endtask

  task automatic test_single_pulse();
    obs_t e, o;
    int   pulses, lat;
    pulses = 0; lat = 0; dir = 0;
    for (int i = 0; i < 8; i++) begin
      jump = (i < 2);
      tick();
      if (dout_p) begin
        pulses++;
        if (lat == 0) lat = i + 1;
      end
    end
    jump = 0;
    vectors++;
    if (pulses != 1 || state !== 2'd1) begin
      $display("FAIL single_pulse got pulses=%0d st=%0d, want pulses=1 st=1", pulses, state);
      miscompares++;
    end
    vectors++;
    if (lat != LAT) begin
      $display("FAIL jump_latency got %0d ticks, want %0d", lat, LAT);
      miscompares++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        $display("FAIL single_pulse_sb got st=%0d p=%b q=%b t=%b exp st=%0d p=%b q=%b t=%b", o.st, o.p, o.q, o.t, e.st, e.p, e.q, e.t);
        miscompares++;
      end
    end
  endtask

  task automatic test_up_wrap();
    obs_t e, o;
    int   exp_st[5];
    int   pulses, qcyc;
    exp_st = '{1, 2, 3, 0, 1};
    pulses = 0; qcyc = 0; dir = 0;
    clr = 1; tick(); clr = 0;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) begin
        jump = (i == 0);
        tick();
        if (dout_p) pulses++;
        if (dout_q) qcyc++;
      end
      vectors++;
      if (state !== 2'(exp_st[k])) begin
        $display("FAIL up_wrap step%0d got st=%0d, want %0d", k, state, exp_st[k]);
        miscompares++;
      end
    end
    vectors++;
    if (pulses != 5 || qcyc != 4) begin
      $display("FAIL up_wrap_counts got pulses=%0d q_cycles=%0d, want 5 and 4", pulses, qcyc);
      miscompares++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        $display("FAIL up_wrap_sb got st=%0d p=%b q=%b t=%b exp st=%0d p=%b q=%b t=%b", o.st, o.p, o.q, o.t, e.st, e.p, e.q, e.t);
        miscompares++;
      end
    end
  endtask

  task automatic test_down_wrap();
    obs_t e, o;
    int   pulses;
    pulses = 0;
    clr = 1; tick(); clr = 0;
    dir = 1;
    for (int i = 0; i < 3; i++) begin
      jump = (i == 0);
      tick();
      if (dout_p) pulses++;
    end
    vectors++;
    if (state !== 2'd3 || dout_q !== 1'b1 || pulses != 1) begin
      $display("FAIL down_wrap got st=%0d q=%b pulses=%0d, want st=3 q=1 pulses=1", state, dout_q, pulses);
      miscompares++;
    end
    dir = 0; tick(); dir = 1; tick(); dir = 0; tick();
    vectors++;
    if (state !== 2'd3 || dout_p !== 1'b0) begin
      $display("FAIL dir_no_edge got st=%0d p=%b, want st=3 p=0", state, dout_p);
      miscompares++;
    end
    clr = 1; tick(); clr = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        $display("FAIL down_wrap_sb got st=%0d p=%b q=%b t=%b exp st=%0d p=%b q=%b t=%b", o.st, o.p, o.q, o.t, e.st, e.p, e.q, e.t);
        miscompares++;
      end
    end
  endtask

  task automatic test_timeout();
    obs_t e, o;
    int   n, tpulses;
    dir = 0; tpulses = 0;
    jump = 1; tick(); jump = 0;
    n = 0;
    while (state !== 2'd1 && n < 10) begin tick(); n++; end
    n = 0;
    while (state !== 2'd0 && n < 20) begin
      tick(); n++;
      if (timeout) tpulses++;
    end
    vectors++;
    if (n != HOLD || timeout !== 1'b1 || dout_p !== 1'b1) begin
      $display("FAIL timeout_return got %0d cycles t=%b p=%b, want %0d cycles t=1 p=1", n, timeout, dout_p, HOLD);
      miscompares++;
    end
    tick();
    if (timeout) tpulses++;
    vectors++;
    if (tpulses != 1 || timeout !== 1'b0) begin
      $display("FAIL timeout_pulse got pulses=%0d t=%b, want 1 pulse then 0", tpulses, timeout);
      miscompares++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        $display("FAIL timeout_sb got st=%0d p=%b q=%b t=%b exp st=%0d p=%b q=%b t=%b", o.st, o.p, o.q, o.t, e.st, e.p, e.q, e.t);
        miscompares++;
      end
    end
  endtask

  task automatic test_timeout_jump();
    obs_t e, o;
    int   n, tseen;
    dir = 0; tseen = 0;
    jump = 1; tick(); jump = 0;
    n = 0;
    while (state !== 2'd1 && n < 10) begin tick(); n++; end
    // place the synchronised edge exactly on the expiry cycle
    for (int i = 0; i < HOLD - LAT; i++) begin
      tick();
      if (timeout) tseen++;
    end
    jump = 1;
    for (int i = 0; i < LAT; i++) begin
      tick();
      if (timeout) tseen++;
    end
    jump = 0;
    tick();
    if (timeout) tseen++;
    vectors++;
    if (state !== 2'd2 || tseen != 0) begin
      $display("FAIL timeout_vs_jump got st=%0d timeouts=%0d, want st=2 timeouts=0", state, tseen);
      miscompares++;
    end
    clr = 1; tick(); clr = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        $display("FAIL timeout_jump_sb got st=%0d p=%b q=%b t=%b exp st=%0d p=%b q=%b t=%b", o.st, o.p, o.q, o.t, e.st, e.p, e.q, e.t);
        miscompares++;
      end
    end
  endtask

  task automatic test_clr_priority();
    obs_t e, o;
    dir = 0;
    jump = 1; tick(); jump = 0; tick(); tick();
    jump = 1; clr = 1;
    for (int i = 0; i < LAT; i++) tick();
    clr = 0;
    vectors++;
    if (state !== 2'd0) begin
      $display("FAIL clr_vs_jump got st=%0d, want 0", state);
      miscompares++;
    end
    tick(); tick(); tick();
    vectors++;
    if (state !== 2'd0) begin
      $display("FAIL held_level got st=%0d, want 0", state);
      miscompares++;
    end
    jump = 0; clr = 1; tick(); clr = 0;
    vectors++;
    if (dout_p !== 1'b0 || state !== 2'd0) begin
      $display("FAIL clr_in_zero got st=%0d p=%b, want st=0 p=0", state, dout_p);
      miscompares++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        $display("FAIL clr_sb got st=%0d p=%b q=%b t=%b exp st=%0d p=%b q=%b t=%b", o.st, o.p, o.q, o.t, e.st, e.p, e.q, e.t);
        miscompares++;
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t e, o;
    dir = 0;
    for (int k = 0; k < 2; k++) begin
      jump = 1; tick(); jump = 0; tick(); tick(); tick();
    end
    vectors++;
    if (state !== 2'd2) begin
      $display("FAIL pre_reset got st=%0d, want 2", state);
      miscompares++;
    end
    #4 rst = 1'b1;
    #1;
    vectors++;
    if ({state, dout_p, dout_q, timeout} !== 5'b0) begin
      $display("FAIL async_reset got st=%0d p=%b q=%b t=%b, want all 0 before edge", state, dout_p, dout_q, timeout);
      miscompares++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    tick();
    jump = 1; tick(); jump = 0; tick(); tick(); tick();
    vectors++;
    if (state !== 2'd1) begin
      $display("FAIL post_reset_jump got st=%0d, want 1", state);
      miscompares++;
    end
    clr = 1; tick(); clr = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        $display("FAIL async_reset_sb got st=%0d p=%b q=%b t=%b exp st=%0d p=%b q=%b t=%b", o.st, o.p, o.q, o.t, e.st, e.p, e.q, e.t);
        miscompares++;
      end
    end
  endtask

  task automatic test_jump_high_at_release();
    obs_t e, o;
    int   pulses;
    pulses = 0; dir = 0;
    rst = 1'b1; jump = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (dout_p) pulses++;
    end
    vectors++;
    if (state !== 2'd0 || pulses != 0) begin
      $display("FAIL held_at_release got st=%0d pulses=%0d, want st=0 pulses=0", state, pulses);
      miscompares++;
    end
    jump = 0; tick();
    jump = 1; tick(); jump = 0; tick(); tick(); tick();
    vectors++;
    if (state !== 2'd1) begin
      $display("FAIL first_real_edge got st=%0d, want 1", state);
      miscompares++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        $display("FAIL release_sb got st=%0d p=%b q=%b t=%b exp st=%0d p=%b q=%b t=%b", o.st, o.p, o.q, o.t, e.st, e.p, e.q, e.t);
        miscompares++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_pulse();
    test_up_wrap();
    test_down_wrap();
    test_timeout();
    test_timeout_jump();
    test_clr_priority();
    test_async_reset();
    test_jump_high_at_release();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
